// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
//   Generic inter-stage pipeline register with a valid/ready handshake and a
//   2-entry skid buffer. A downstream stall reaches the upstream stage one
//   cycle late, through the registered in_ready, without losing data.
//   Control payload and data payload read as zero whenever the head entry is
//   invalid, so bubbles never carry stale reg_write/mem_write bits.
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous clear of both held entries (input that cycle dropped)
//   in_valid   upstream presents an entry
//   in_ready   stage can accept (registered; independent of out_ready)
//   in_ctrl    upstream control payload
//   in_data    upstream data payload
//   out_valid  head entry valid
//   out_ready  downstream accepts head this cycle
//   out_ctrl   head control payload, 0 when out_valid=0
//   out_data   head data payload, 0 when out_valid=0
//   occ        number of entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipeline_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy doubles as the state encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              acc;
    logic              pop;

    assign out_valid = (state != EMPTY);
    assign in_ready  = ready_q;
    assign occ       = state;
    assign acc       = in_valid && ready_q;
    assign pop       = out_valid && out_ready;

    // Bubble rule: gate payloads so an invalid head always reads as zero.
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign out_data  = out_valid ? head_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            ready_q   <= 1'b0;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            stall_cnt <= '0;
        end else begin
            // Flush does not clear the counter, but a flushed cycle is not counted.
            if (out_valid && !out_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            if (flush) begin
                state     <= EMPTY;
                ready_q   <= 1'b1;
                head_ctrl <= '0;
                head_data <= '0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        ready_q <= 1'b1;
                        if (acc) begin
                            state     <= ONE;
                            head_ctrl <= in_ctrl;
                            head_data <= in_data;
                        end
                    end
                    ONE: begin
                        if (acc && pop) begin
                            head_ctrl <= in_ctrl;
                            head_data <= in_data;
                            ready_q   <= 1'b1;
                        end else if (acc) begin
                            // Downstream stalled: park the new entry in the skid slot
                            // and drop in_ready for the following cycle.
                            state     <= FULL;
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                            ready_q   <= 1'b0;
                        end else if (pop) begin
                            state     <= EMPTY;
                            head_ctrl <= '0;
                            head_data <= '0;
                            ready_q   <= 1'b1;
                        end else begin
                            ready_q   <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state     <= ONE;
                            head_ctrl <= skid_ctrl;
                            head_data <= skid_data;
                            skid_ctrl <= '0;
                            skid_data <= '0;
                            ready_q   <= 1'b1;
                        end else begin
                            ready_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
